// File: rtl/alu_sequencer.sv
// alu_sequencer: round-robin sharing of one external combinational ALU between two
// requesters, with registered operands, per-opcode wait and a valid/ready response.
// Optional macro ALU_SEQ_PERF_EN adds perf_ops / perf_stall counters.
module alu_sequencer #(
    parameter int             WIDTH   = 32,
    parameter int             FN_W    = 6,
    parameter logic [FN_W-1:0] MUL_FN = 6'b000010,
    parameter int             MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FN_W-1:0]  req0_fn,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FN_W-1:0]  req1_fn,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FN_W-1:0]  alufn,
    input  logic [WIDTH-1:0] alu_otp,
    input  logic             alu_overflow,
    input  logic             alu_zero,
`ifdef ALU_SEQ_PERF_EN
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_overflow,
    output logic             rsp_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            last_grant;
    logic            gnt0, gnt1;
    logic [FN_W-1:0] sel_fn;

    // Round-robin: with both valid, the requester not granted last time wins.
    always_comb begin
        gnt0       = req0_valid && (!req1_valid || last_grant);
        gnt1       = req1_valid && (!req0_valid || !last_grant);
        req0_ready = rst_n && state == IDLE && gnt0;
        req1_ready = rst_n && state == IDLE && gnt1;
        sel_fn     = gnt1 ? req1_fn : req0_fn;
    end

    // Sequencer: accept in IDLE, count down in EXEC, hold the response in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alufn        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    alu_a      <= gnt1 ? req1_a : req0_a;
                    alu_b      <= gnt1 ? req1_b : req0_b;
                    alufn      <= sel_fn;
                    rsp_id     <= gnt1;
                    last_grant <= gnt1;
                    cnt        <= (sel_fn == MUL_FN) ? 4'(MUL_LAT - 1) : 4'd0;
                    state      <= EXEC;
                end
                EXEC: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_data     <= alu_otp;
                    rsp_overflow <= alu_overflow;
                    rsp_zero     <= alu_zero;
                    rsp_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Handoff and backpressure counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready) perf_ops <= perf_ops + 32'd1;
            if (state == DONE && !rsp_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [5:0]  req0_fn = '0, req1_fn = '0;
    logic [31:0] alu_a, alu_b, alu_otp;
    logic [5:0]  alufn;
    logic        alu_overflow, alu_zero;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_overflow, rsp_zero;
    logic [31:0] rsp_data;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_ops, perf_stall;
`endif
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fn(req0_fn),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fn(req1_fn),
        .alu_a(alu_a), .alu_b(alu_b), .alufn(alufn),
        .alu_otp(alu_otp), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
`ifdef ALU_SEQ_PERF_EN
        .perf_ops(perf_ops), .perf_stall(perf_stall),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero)
    );

    always_comb begin
        case (alufn)
            6'd0:    alu_otp = alu_a + alu_b;
            6'd1:    alu_otp = alu_a - alu_b;
            6'd2:    alu_otp = alu_a * alu_b;
            6'd3:    alu_otp = alu_a << alu_b[4:0];
            6'd4:    alu_otp = alu_a >> alu_b[4:0];
            default: alu_otp = alu_a ^ alu_b;
        endcase
        alu_overflow = (alufn == 6'd0) ? (alu_a[31] == alu_b[31]) && (alu_otp[31] != alu_a[31]) :
                       (alufn == 6'd1) ? (alu_a[31] != alu_b[31]) && (alu_otp[31] != alu_a[31]) : 1'b0;
        alu_zero = (alu_otp == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for rsp_valid after an accept edge; n-1 is the accept-to-valid latency.
    task automatic wait_rsp(input bit drop, input logic [31:0] ea, input logic [5:0] efn, output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (drop) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            n++;
            if (!rsp_valid) begin
                chk("exec_alu_a", alu_a, ea);
                chk("exec_alufn", {26'd0, alufn}, {26'd0, efn});
            end
        end while (!rsp_valid && n < 20);
        chk("rsp_arrives", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic op(input bit id, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input bit expz, input int lat, input int stall);
        int n;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fn = fn;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fn = fn;
        end
        rsp_ready = (stall == 0);
        #1;
        chk("grant_ready", {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        wait_rsp(1'b1, a, fn, n);
        chk("latency", n - 1, lat);
        chk("rsp_data", rsp_data, exp);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, id});
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, expz});
        chk("rsp_overflow", {31'd0, rsp_overflow}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_data", rsp_data, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        req0_valid = 1'b1;
        #3;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alufn", {26'd0, alufn}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;

        op(1'b0, 6'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1, 0);
        op(1'b0, 6'd2, 32'h13, 32'd2, 32'h26, 1'b0, 4, 0);
        op(1'b1, 6'd1, 32'h13, 32'd2, 32'h11, 1'b0, 1, 0);
        op(1'b1, 6'd1, 32'd5, 32'd5, 32'd0, 1'b1, 1, 0);

        // Both requesters held valid: grants alternate starting with req0.
        @(negedge clk);
        req0_a = 32'd1;    req0_b = 32'd3; req0_fn = 6'd3; req0_valid = 1'b1;
        req1_a = 32'h10;   req1_b = 32'd3; req1_fn = 6'd4; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(req0_ready || req1_ready) && n < 10) begin
                @(negedge clk); #1; n++;
            end
            chk("arb_ready", {31'd0, req0_ready | req1_ready}, 32'd1);
            chk("arb_grant", {31'd0, req1_ready}, k % 2);
            wait_rsp(1'b0, (k % 2) ? 32'h10 : 32'd1, (k % 2) ? 6'd4 : 6'd3, n);
            chk("arb_data", rsp_data, (k % 2) ? 32'd2 : 32'd8);
            chk("arb_id", {31'd0, rsp_id}, k % 2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk); @(negedge clk);

        // Backpressure: response held, pending req1 not granted until handoff.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_fn = 6'd0;
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready", {31'd0, req0_ready}, 32'd1);
        wait_rsp(1'b1, 32'd2, 6'd0, n);
        chk("bp_data0", rsp_data, 32'd5);
        req1_valid = 1'b1; req1_fn = 6'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_data, 32'd5);
            chk("bp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("bp_cleared", {31'd0, rsp_valid}, 32'd0);
        chk("bp_data_kept", rsp_data, 32'd5);
        chk("bp_pending_grant", {31'd0, req1_ready}, 32'd1);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_drop_idle", {31'd0, req1_ready | rsp_valid}, 32'd0);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd3; req0_fn = 6'd2;
        #1;
        chk("mr_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        chk("mr_exec_a", alu_a, 32'd7);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("mr_rst_alu_a", alu_a, 32'd0);
        chk("mr_rst_alu_b", alu_b, 32'd0);
        chk("mr_rst_alufn", {26'd0, alufn}, 32'd0);
        chk("mr_rst_data", rsp_data, 32'd0);
        chk("mr_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mr_rst_ready", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mr_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

`ifdef ALU_SEQ_PERF_EN
        op(1'b0, 6'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1, 2);
        op(1'b1, 6'd1, 32'd9, 32'd4, 32'd5, 1'b0, 1, 3);
        op(1'b0, 6'd2, 32'd3, 32'd3, 32'd9, 1'b0, 4, 0);
        chk("perf_ops", perf_ops, 32'd3);
        chk("perf_stall", perf_stall, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Shares one combinational 32-bit ALU instance between two requesters: req0 (execute stage) and req1 (branch/address unit).
- Does round-robin arbitration, registers the operands and function code that drive the ALU, and waits a per-opcode number of cycles (multiply is slower).
- Captures the ALU result and flags and returns them through a valid/ready response channel tagged with the requester ID.

Parameters:
WIDTH, 32, operand/result width
FN_W, 6, ALU function-code width
MUL_FN, 6'b000010, function code treated as multi-cycle multiply
MUL_LAT, 4, EXEC cycles for MUL_FN (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a, req0_b  in  WIDTH  requester 0 operands
req0_fn  in  FN_W  requester 0 ALU function
req1_valid, req1_ready, req1_a, req1_b, req1_fn  as req0, for requester 1
alu_a, alu_b  out  WIDTH  registered operands to ALU
alufn  out  FN_W  registered function to ALU
alu_otp  in  WIDTH  ALU result
alu_overflow, alu_zero  in  1  ALU flags
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that owns the response
rsp_data  out  WIDTH  captured result
rsp_overflow, rsp_zero  out  1  captured flags

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; alu_a=0, alu_b=0, alufn=0; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_overflow=0, rsp_zero=0; cnt=0; last_grant=1, so req0 wins first.
- reqN_ready is combinational and is high only in IDLE for the granted requester. It is 0 during reset.
- Reset asserted mid-operation aborts the in-flight op. No response is produced.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Neither valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - On grant: assert reqN_ready; on the next edge latch a/b/fn into alu_a/alu_b/alufn, set rsp_id=N and last_grant=N, load cnt=(fn==MUL_FN ? MUL_LAT-1 : 0), and go to EXEC.
- EXEC:
  - alu_* are held stable.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture alu_otp/alu_overflow/alu_zero into rsp_*, set rsp_valid=1, and go to DONE.
- DONE:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1, clear rsp_valid on the edge and go to IDLE. rsp_data keeps its last value.
  - No new grant is given in the same cycle.
- Latency from the accept edge to rsp_valid: 1 cycle for non-multiply ops, MUL_LAT cycles for MUL_FN.
- Minimum issue interval with rsp_ready tied high: 3 cycles (non-multiply), MUL_LAT+2 (multiply).
- Requests are not accepted outside IDLE. Held requests stay pending; a requester may drop valid before it is granted.
- rsp_ready is ignored when rsp_valid=0.
- The function code is passed through unchecked. Undefined codes take 1 cycle and return whatever the ALU produces.

Optional Feature:
Macro: ALU_SEQ_PERF_EN.
- Defined: adds outputs perf_ops (32, count of responses handed off) and perf_stall (32, cycles in DONE with rsp_ready=0).
  - Both reset to 0 and wrap modulo 2^32.
  - perf_ops increments on the rsp_valid&&rsp_ready edge.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Add: req0 fn=000000, a=1, b=1 -> req0_ready for 1 cycle; rsp_valid 1 cycle after accept; rsp_data=2, rsp_id=0, rsp_zero=0.
- Subtract and zero flag: req1 fn=000001, a=0x13, b=0x2 -> rsp_data=0x11, rsp_id=1. Then a=b=5 -> rsp_data=0, rsp_zero=1.
- Multiply latency: fn=000010, a=0x13, b=2, MUL_LAT=4 -> rsp_valid exactly 4 cycles after accept; rsp_data=0x26; alu_a/alufn stable through EXEC.
- Arbitration: both requesters valid continuously (req0 shl 1<<3, req1 shr 0x10>>3) with rsp_ready=1 -> grants alternate 0,1,0,1. Responses return 8 then 2 with the matching rsp_id.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles -> rsp_* stable and no req_ready. Then assert rst_n=0 during an EXEC multiply -> all outputs go to reset values immediately, and no response appears after release.
- With ALU_SEQ_PERF_EN: 3 ops with 5 stall cycles in total -> perf_ops=3, perf_stall=5.
